// File: rtl/tsp_collect_pkg.sv
// Shared constants, FSM state encoding and the rebasing helper for the TSP match collector.
package tsp_collect_pkg;

    localparam logic [15:0] END_CODE  = 16'hFFFF;
    localparam logic [7:0]  TAG_MATCH = 8'h01;
    localparam logic [7:0]  TAG_END   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_END,
        ST_DONE
    } state_e;

    // Decoder positions are signed offsets relative to the block base; the result wraps at 2^24.
    function automatic logic [23:0] rebase(input logic [23:0] base, input logic [15:0] rel);
        return base + {{8{rel[15]}}, rel};
    endfunction

endpackage

// File: rtl/tsp_collect_buf.sv
// DEPTH x WIDTH synchronous FIFO with occupancy output; buffers rebased match records.
module tsp_collect_buf
    import tsp_collect_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    // NOTE: the storage array is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW + 1)'(push_i) - (AW + 1)'(pop_i);
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    assert property (@(posedge clk) disable iff (reset) !(push_i && !pop_i && count_q == FULL));
    assert property (@(posedge clk) disable iff (reset) !(pop_i && count_q == '0));

endmodule

// File: rtl/tsp_match_collector.sv
// Pops TSP decoder match records, rebases them and streams tagged words plus one end record per run.
// Optional TSP_COLLECT_CHECK_EN compares the final count against the decoder's expected_count.
module tsp_match_collector
    import tsp_collect_pkg::*;
#(
    parameter int COUNT_WIDTH = 15,
    parameter int BUF_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [23:0]            base_offset,
    input  logic                   in_empty,
    output logic                   in_rden,
    input  logic                   in_valid,
    input  logic [15:0]            in_data,
    input  logic [COUNT_WIDTH-1:0] expected_count,
    output logic [31:0]            out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] match_total,
    output logic                   done,
    output logic                   stray,
    output logic                   count_mismatch
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(BUF_DEPTH);

    state_e                 state_q, state_d;
    logic [23:0]            base_q, base_d;
    logic [COUNT_WIDTH-1:0] match_total_q, match_total_d;
    logic                   stray_q, stray_d;
    logic                   out_valid_q, out_valid_d;
    logic [31:0]            out_data_q, out_data_d;
    logic                   rd_pend_q;
    logic                   post_reset_q;

    logic          start_ok, cap_run, cap_end, cap_match, out_free;
    logic          buf_push, buf_pop;
    logic [31:0]   match_word, buf_data;
    logic [CW-1:0] buf_count;
    logic [CW:0]   occupancy;

    assign start_ok   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign cap_run    = in_valid && (state_q == ST_RUN);
    assign cap_end    = cap_run && (in_data == END_CODE);
    assign cap_match  = cap_run && !cap_end;
    assign match_word = {TAG_MATCH, rebase(base_q, in_data)};

    // The output register counts as a buffer slot, so at most BUF_DEPTH words are ever in flight.
    assign occupancy = {1'b0, buf_count} + (CW + 1)'(out_valid_q) + (CW + 1)'(rd_pend_q);
    assign in_rden   = (state_q == ST_RUN) && !in_empty && !cap_end && (occupancy < CREDITS);

    assign out_free = !out_valid_q || out_ready;
    assign buf_pop  = out_free && (buf_count != '0);
    assign buf_push = cap_match && !(out_free && buf_count == '0);

    tsp_collect_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (32)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (buf_push),
        .push_data_i (match_word),
        .pop_i       (buf_pop),
        .pop_data_o  (buf_data),
        .count_o     (buf_count)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (out_free) begin
            out_valid_d = 1'b0;
            if (buf_count != '0) begin
                out_valid_d = 1'b1;
                out_data_d  = buf_data;
            end else if (cap_match) begin
                out_valid_d = 1'b1;
                out_data_d  = match_word;
            end else if (state_q == ST_END && !out_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = {TAG_END, 24'(match_total_q)};
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        match_total_d = match_total_q;
        stray_d       = stray_q;
        case (state_q)
            ST_RUN:   if (cap_end) state_d = ST_DRAIN;
            ST_DRAIN: if (buf_count == '0 && !out_valid_q) state_d = ST_END;
            ST_END:   if (out_valid_q && out_ready) state_d = ST_DONE;
            ST_IDLE, ST_DONE: state_d = state_q;
            default:  state_d = ST_IDLE;
        endcase
        if (cap_match && match_total_q != '1) begin
            match_total_d = match_total_q + 1'b1;
        end
        // A read issued just before reset may land in IDLE; that one is not a stray.
        if (in_valid && state_q != ST_RUN && !post_reset_q) begin
            stray_d = 1'b1;
        end
        if (start_ok) begin
            state_d       = ST_RUN;
            base_d        = base_offset;
            match_total_d = '0;
            stray_d       = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            match_total_q <= '0;
            stray_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            rd_pend_q     <= 1'b0;
            post_reset_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            match_total_q <= match_total_d;
            stray_q       <= stray_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            rd_pend_q     <= in_rden;
            post_reset_q  <= 1'b0;
        end
    end

`ifdef TSP_COLLECT_CHECK_EN
    logic mismatch_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch_q <= 1'b0;
        end else if (start_ok) begin
            mismatch_q <= 1'b0;
        end else if (state_q == ST_DRAIN && state_d == ST_END) begin
            mismatch_q <= (match_total_q != expected_count);
        end
    end

    assign count_mismatch = mismatch_q;
`else
    logic unused_expected;
    assign unused_expected = ^expected_count;
    assign count_mismatch  = 1'b0;
`endif

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign match_total = match_total_q;
    assign done        = (state_q == ST_DONE);
    assign stray       = stray_q;

endmodule

// File: tb/tb_tsp_match_collector.sv
// Directed, table-driven bench for tsp_match_collector with a behavioural decoder FIFO and output sink.
module tb_tsp_match_collector;

    localparam int COUNT_WIDTH = 15;
    localparam int BUF_DEPTH   = 4;

`ifdef TSP_COLLECT_CHECK_EN
    localparam logic [31:0] MM_WHEN_SHORT = 32'd1;
`else
    localparam logic [31:0] MM_WHEN_SHORT = 32'd0;
`endif

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   start = 1'b0;
    logic [23:0]            base_offset = '0;
    logic                   in_empty = 1'b1;
    logic                   in_rden;
    logic                   in_valid = 1'b0;
    logic [15:0]            in_data = '0;
    logic [COUNT_WIDTH-1:0] expected_count = '0;
    logic [31:0]            out_data;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [COUNT_WIDTH-1:0] match_total;
    logic                   done;
    logic                   stray;
    logic                   count_mismatch;

    tsp_match_collector #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .BUF_DEPTH   (BUF_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_offset    (base_offset),
        .in_empty       (in_empty),
        .in_rden        (in_rden),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .expected_count (expected_count),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .match_total    (match_total),
        .done           (done),
        .stray          (stray),
        .count_mismatch (count_mismatch)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Decoder FIFO contents: written by the stimulus, consumed by the FIFO model.
    logic [15:0] src_mem [256];
    int          src_wr = 0;
    int          src_rd = 0;
    int          flush_req = 0, flush_ack = 0;
    int          inj_req = 0, inj_ack = 0;
    logic [15:0] inj_data = '0;

    // Sink / monitor state, written only by the negedge monitor.
    logic        rd_s = 1'b0;
    int          rden_cnt = 0;
    int          cyc = 0;
    logic [31:0] got [$];
    int          got_cyc [$];

    always @(negedge clk) begin
        cyc++;
        rd_s = in_rden;
        if (in_rden === 1'b1) rden_cnt++;
        if (!reset && out_valid === 1'b1 && out_ready) begin
            got.push_back(out_data);
            got_cyc.push_back(cyc);
        end
    end

    // Read data appears one cycle after the pop; the empty flag reflects the pop right away.
    always begin
        logic [15:0] d;
        logic        have;
        @(posedge clk);
        have = 1'b0;
        d    = '0;
        if (rd_s && src_rd < src_wr) begin
            d    = src_mem[src_rd % 256];
            src_rd++;
            have = 1'b1;
        end
        if (flush_req != flush_ack) begin
            src_rd    = src_wr;
            flush_ack = flush_req;
        end
        #1;
        if (have) begin
            in_valid = 1'b1;
            in_data  = d;
        end else if (inj_req != inj_ack) begin
            in_valid = 1'b1;
            in_data  = inj_data;
            inj_ack  = inj_req;
        end else begin
            in_valid = 1'b0;
        end
        in_empty = (src_rd == src_wr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] got_at(input int k);
        return (k < got.size()) ? got[k] : 32'hxxxx_xxxx;
    endfunction

    task automatic load(input logic [15:0] w);
        src_mem[src_wr % 256] = w;
        src_wr++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run(input logic [23:0] b);
        @(posedge clk);
        #1;
        base_offset = b;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int c = 0;
        while (done !== 1'b1 && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    typedef struct {
        logic [23:0] base;
        logic [15:0] data;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int g0;
        int rc0;

        vecs[0] = '{24'h000010, 16'hFFFE, 32'h0100_000E};
        vecs[1] = '{24'hFFFFFF, 16'h0002, 32'h0100_0001};
        vecs[2] = '{24'h000100, 16'h0005, 32'h0100_0105};
        vecs[3] = '{24'h123456, 16'h8000, 32'h0111_B456};
        vecs[4] = '{24'h000000, 16'h7FFF, 32'h0100_7FFF};
        vecs[5] = '{24'hABCDEF, 16'h0000, 32'h01AB_CDEF};

        // Reset values
        tick(2);
        reset = 1'b0;
        check("rst_in_rden", 32'(in_rden), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_match_total", 32'(match_total), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stray", 32'(stray), 32'd0);
        check("rst_mismatch", 32'(count_mismatch), 32'd0);

        // Basic two-match run
        out_ready = 1'b1;
        g0 = got.size();
        load(16'h0005);
        load(16'h0010);
        load(16'hFFFF);
        start_run(24'h000100);
        wait_done("basic_done", 100);
        check("basic_nwords", 32'(got.size() - g0), 32'd3);
        check("basic_w0", got_at(g0), 32'h0100_0105);
        check("basic_w1", got_at(g0 + 1), 32'h0100_0110);
        check("basic_end", got_at(g0 + 2), 32'hFF00_0002);
        check("basic_total", 32'(match_total), 32'd2);

        // Rebasing table: one match then the end code per run
        for (int i = 0; i < 6; i++) begin
            g0 = got.size();
            load(vecs[i].data);
            load(16'hFFFF);
            start_run(vecs[i].base);
            wait_done($sformatf("vec%0d_done", i), 100);
            check($sformatf("vec%0d_word", i), got_at(g0), vecs[i].exp_word);
            check($sformatf("vec%0d_end", i), got_at(g0 + 1), 32'hFF00_0001);
            check($sformatf("vec%0d_nwords", i), 32'(got.size() - g0), 32'd2);
        end

        // Sustained throughput: back-to-back words with out_ready high
        g0 = got.size();
        for (int i = 0; i < 6; i++) load(16'(16'h0010 + i));
        load(16'hFFFF);
        start_run(24'h000200);
        wait_done("thr_done", 100);
        check("thr_nwords", 32'(got.size() - g0), 32'd7);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("thr_w%0d", i), got_at(g0 + i), 32'h0100_0210 + 32'(i));
        end
        if (got.size() >= g0 + 6) begin
            check("thr_span", 32'(got_cyc[g0 + 5] - got_cyc[g0]), 32'd5);
        end else begin
            check("thr_span", 32'hFFFF_FFFF, 32'd5);
        end

        // Back-pressure: sink stalled 10 cycles, credits cap the pops
        out_ready = 1'b0;
        g0 = got.size();
        for (int i = 0; i < 8; i++) load(16'(16'h0001 + 3 * i));
        load(16'hFFFF);
        start_run(24'h001000);
        rc0 = rden_cnt;
        tick(5);
        check("stall_valid_a", 32'(out_valid), 32'd1);
        check("stall_data_a", out_data, 32'h0100_1001);
        start_run(24'h00FFFF);
        tick(3);
        check("stall_rden_cnt", 32'(rden_cnt - rc0), 32'(BUF_DEPTH));
        check("stall_valid_b", 32'(out_valid), 32'd1);
        check("stall_data_b", out_data, 32'h0100_1001);
        out_ready = 1'b1;
        wait_done("stall_done", 200);
        check("stall_nwords", 32'(got.size() - g0), 32'd9);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("stall_w%0d", i), got_at(g0 + i), 32'h0100_1001 + 32'(3 * i));
        end
        check("stall_end", got_at(g0 + 8), 32'hFF00_0008);
        check("stall_total", 32'(match_total), 32'd8);

        // Count checker, short run, then a word after the end code
        expected_count = 15'd3;
        load(16'h0001);
        load(16'h0002);
        load(16'hFFFF);
        start_run(24'h000000);
        wait_done("chk3_done", 100);
        check("chk3_mismatch", 32'(count_mismatch), MM_WHEN_SHORT);
        expected_count = 15'd2;
        load(16'h0001);
        load(16'h0002);
        load(16'hFFFF);
        start_run(24'h000000);
        wait_done("chk2_done", 100);
        check("chk2_mismatch", 32'(count_mismatch), 32'd0);
        check("stray_before", 32'(stray), 32'd0);
        inj_data = 16'h1234;
        inj_req++;
        tick(3);
        check("stray_after", 32'(stray), 32'd1);
        check("stray_done_holds", 32'(done), 32'd1);

        // End code only
        g0 = got.size();
        load(16'hFFFF);
        start_run(24'h000ABC);
        check("only_stray_cleared", 32'(stray), 32'd0);
        check("only_done_cleared", 32'(done), 32'd0);
        wait_done("only_done", 100);
        check("only_nwords", 32'(got.size() - g0), 32'd1);
        check("only_end", got_at(g0), 32'hFF00_0000);
        check("only_total", 32'(match_total), 32'd0);

        // Reset in the middle of a streaming run with a read in flight
        for (int i = 0; i < 20; i++) load(16'(i));
        start_run(24'h000000);
        tick(4);
        check("mid_valid_pre", 32'(out_valid), 32'd1);
        reset = 1'b1;
        flush_req++;
        tick(1);
        reset = 1'b0;
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_in_rden", 32'(in_rden), 32'd0);
        check("mid_total", 32'(match_total), 32'd0);
        check("mid_out_data", out_data, 32'd0);
        check("mid_done", 32'(done), 32'd0);
        tick(2);
        check("mid_stray", 32'(stray), 32'd0);
        g0 = got.size();
        load(16'h0004);
        load(16'hFFFF);
        start_run(24'h000000);
        wait_done("mid_rerun_done", 100);
        check("mid_rerun_nwords", 32'(got.size() - g0), 32'd2);
        check("mid_rerun_w0", got_at(g0), 32'h0100_0004);
        check("mid_rerun_end", got_at(g0 + 1), 32'hFF00_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
